scanner_byte_tx: RTL

//  Scanner-side transmit stage, directly upstream of the transfer center.
//  - Buffers scanned bytes in a FIFO.
//  - Raises readyForTransferOut once enough bytes are held.
//  - When the transfer center grants via readyForTransferIn, serializes the burst on dataOut.
//  - dataOut is the transfer center's dataIn.

---
 rtl/scanner_byte_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/scanner_byte_tx.sv
// Scanner transmit stage: byte FIFO feeding a start/8-data/stop serializer toward the transfer center.
// Optional even-parity bit between data and stop when PARITY_EN is defined.
module scanner_byte_tx #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned PTR_W       = 3,
   parameter int unsigned READY_LEVEL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scanValid,
   input  logic [7:0]       scanByte,
   output logic             scanReady,
   input  logic             readyForTransferIn,
   output logic             readyForTransferOut,
   output logic             dataOut,
   output logic [PTR_W:0]   fillCount,
   output logic             busy,
   output logic             overflow
);

`ifdef PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_LEVEL = (PTR_W+1)'(READY_LEVEL);
   localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count, count_nxt;
   logic [PTR_W:0]   burst_left;
   logic [7:0]       shreg;
   logic [2:0]       bit_cnt;
   logic [7:0]       head;
   logic             push, pop, drop, dout_nxt;
`ifdef PARITY_EN
   logic             par;
`endif

   assign head      = mem[rd_ptr];
   assign pop       = (state == START);
   // The START pop frees a slot on the same edge, so a push at full is still taken then.
   assign push      = scanValid && ((count != CNT_FULL) || pop);
   assign drop      = scanValid && (count == CNT_FULL) && !pop;
   assign scanReady = (count != CNT_FULL);
   assign fillCount = count;
   assign busy      = (state != IDLE);

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CNT_ONE;
      else if (pop && !push)
         count_nxt = count - CNT_ONE;
   end

   // dataOut is registered from the next state, so each output bit lines up with its state.
   always_comb begin
      state_nxt = state;
      dout_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (readyForTransferIn && (count != '0)) begin
               state_nxt = START;
               dout_nxt  = 1'b1;
            end
         end
         START: begin
            state_nxt = DATA;
            dout_nxt  = head[7];
         end
         DATA: begin
            if (bit_cnt == 3'd0) begin
`ifdef PARITY_EN
               state_nxt = PAR;
               dout_nxt  = par;
`else
               state_nxt = STOP;
`endif
            end else begin
               dout_nxt = shreg[7];
            end
         end
`ifdef PARITY_EN
         PAR: state_nxt = STOP;
`endif
         STOP: begin
            if (burst_left != '0) begin
               state_nxt = START;
               dout_nxt  = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= scanByte;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         dataOut             <= 1'b0;
         readyForTransferOut <= 1'b0;
         overflow            <= 1'b0;
         count               <= '0;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         burst_left          <= '0;
         shreg               <= '0;
         bit_cnt             <= '0;
`ifdef PARITY_EN
         par                 <= 1'b0;
`endif
      end else begin
         state               <= state_nxt;
         dataOut             <= dout_nxt;
         readyForTransferOut <= (count_nxt >= CNT_LEVEL) && (state_nxt == IDLE);
         count               <= count_nxt;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (drop)
            overflow <= 1'b1;
         case (state)
            IDLE: begin
               if (state_nxt == START)
                  burst_left <= count;
            end
            START: begin
               shreg      <= {head[6:0], 1'b0};
               bit_cnt    <= 3'd7;
               burst_left <= burst_left - CNT_ONE;
`ifdef PARITY_EN
               par        <= ^head;
`endif
            end
            DATA: begin
               if (bit_cnt != 3'd0) begin
                  shreg   <= {shreg[6:0], 1'b0};
                  bit_cnt <= bit_cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
